// File: rtl/ls253_scan_pkg.sv
// Shared types and sizes for the 74LS253 scan controller.
package ls253_scan_pkg;

  localparam int NUM_CH  = 4;
  localparam int NUM_SEC = 2;
  localparam int CH_W    = 2;
  localparam int SNAP_W  = NUM_CH * NUM_SEC;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/ls253_settle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module ls253_settle_timer #(
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                expired
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ls253_scan_ctrl.sv
// Scan sequencer for a dual 4-to-1 mux: steps channels, settles, samples Y1/Y2 into a snapshot.
// Define LS253_SCAN_AUTO_EN to let a held start restart the scan directly from DONE.
module ls253_scan_ctrl
  import ls253_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int SETTLE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_SEC-1:0] sec_en,
  output logic               busy,
  output logic               done,
  output logic [SNAP_W-1:0]  data,
  output logic               mux_a,
  output logic               mux_b,
  output logic [NUM_SEC-1:0] mux_en_n,
  input  logic [NUM_SEC-1:0] mux_y
);

  // Counter counts down to zero, so SETTLE lasts load value + 1 cycles.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W-1:0]     LAST_CH     = CH_W'(NUM_CH - 1);

  scan_state_e        state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NUM_SEC-1:0] sec_q, sec_d;
  logic [SNAP_W-1:0]  shadow_q, shadow_d;
  logic [SNAP_W-1:0]  data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CH_W-1:0]    sel_q, sel_d;
  logic [NUM_SEC-1:0] en_n_q, en_n_d;
  logic               tmr_load, tmr_dec, tmr_expired;

  ls253_settle_timer #(
    .SETTLE_W (SETTLE_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    sec_d    = sec_q;
    shadow_d = shadow_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (sec_en != '0)) begin
          sec_d    = sec_en;
          ch_d     = '0;
          shadow_d = '0;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_expired) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SAMPLE: begin
        shadow_d[{ch_q, 1'b0} +: NUM_SEC] = mux_y & sec_q;
        if (ch_q == LAST_CH) begin
          state_d = DONE;
        end else begin
          ch_d     = ch_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef LS253_SCAN_AUTO_EN
        if (start && (sec_en != '0)) begin
          sec_d    = sec_en;
          ch_d     = '0;
          shadow_d = '0;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it after the edge.
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    data_d = done_d ? shadow_d : data_q;
    sel_d  = busy_d ? ch_d : '0;
    en_n_d = busy_d ? ~sec_d : '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      sec_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sel_q    <= '0;
      en_n_q   <= '1;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      sec_q    <= sec_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sel_q    <= sel_d;
      en_n_q   <= en_n_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data     = data_q;
  assign mux_a    = sel_q[0];
  assign mux_b    = sel_q[1];
  assign mux_en_n = en_n_q;

endmodule

// File: tb/tb_ls253_scan_ctrl.sv
// Bench for ls253_scan_ctrl with a behavioural dual 4-to-1 mux and a snapshot reference model.
module tb_ls253_scan_ctrl;

  localparam int SETTLE_CYCLES = 2;
  localparam int LAT = 4 * (SETTLE_CYCLES + 1) + 1;
`ifdef LS253_SCAN_AUTO_EN
  localparam int PERIOD = LAT;
`else
  localparam int PERIOD = LAT + 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] sec_en;
  logic       busy, done;
  logic [7:0] data;
  logic       mux_a, mux_b;
  logic [1:0] mux_en_n;
  logic [1:0] mux_y;

  logic [3:0] d1, d2;
  int total = 0;
  int bad   = 0;

  ls253_scan_ctrl #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SETTLE_W      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sec_en   (sec_en),
    .busy     (busy),
    .done     (done),
    .data     (data),
    .mux_a    (mux_a),
    .mux_b    (mux_b),
    .mux_en_n (mux_en_n),
    .mux_y    (mux_y)
  );

  always #5 clk = ~clk;

  // Mux behaviour: a disabled section reads as 0.
  always_comb begin
    mux_y = {~mux_en_n[1] & d2[{mux_b, mux_a}], ~mux_en_n[0] & d1[{mux_b, mux_a}]};
  end

  function automatic logic [7:0] ref_scan(input logic [1:0] en, input logic [3:0] s1, input logic [3:0] s2);
    logic [7:0] r;
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
      r[2*ch]     = en[0] & s1[ch];
      r[2*ch + 1] = en[1] & s2[ch];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start with sec_en=en and follows the scan; position c is just after the c-th edge past acceptance.
  task automatic do_scan(input logic [1:0] en, input int repulse, output int done_cyc,
                         output logic [7:0] dat, output logic path_ok,
                         output logic [1:0] dn_en_n, output logic dn_busy);
    path_ok  = 1'b1;
    done_cyc = -1;
    dat      = '0;
    dn_en_n  = '0;
    dn_busy  = 1'b1;
    sec_en   = en;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        done_cyc = c;
        dat      = data;
        dn_en_n  = mux_en_n;
        dn_busy  = busy;
        break;
      end
      if (c <= 4 * (SETTLE_CYCLES + 1)) begin
        if ({mux_b, mux_a} !== 2'((c - 1) / (SETTLE_CYCLES + 1)) || mux_en_n !== ~en || busy !== 1'b1)
          path_ok = 1'b0;
      end
      if (c == repulse) begin
        start  = 1'b1;
        sec_en = ~en;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sec_en = 2'b00;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data); end
    total++; if (mux_en_n !== 2'b11) begin bad++; $display("FAIL reset_en_n got=%b want=11", mux_en_n); end
    total++; if ({mux_b, mux_a} !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b want=00", {mux_b, mux_a}); end
  endtask

  task automatic test_basic();
    int dc; logic [7:0] dat; logic ok; logic [1:0] den; logic db;
    d1 = 4'b1101; d2 = 4'b0110;
    do_scan(2'b11, -1, dc, dat, ok, den, db);
    total++; if (dc !== LAT) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", dc, LAT); end
    total++; if (dat !== ref_scan(2'b11, d1, d2)) begin bad++; $display("FAIL basic_data got=%h want=%h", dat, ref_scan(2'b11, d1, d2)); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_select_path got=%b want=1", ok); end
    total++; if (db !== 1'b0) begin bad++; $display("FAIL basic_done_busy got=%b want=0", db); end
    total++; if (den !== 2'b11) begin bad++; $display("FAIL basic_done_en_n got=%b want=11", den); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    total++; if (data !== 8'h79) begin bad++; $display("FAIL basic_data_hold got=%h want=79", data); end
  endtask

  task automatic test_sec1_only();
    int dc; logic [7:0] dat; logic ok; logic [1:0] den; logic db; logic seen_busy, seen_done;
    d1 = 4'b1101; d2 = 4'b0110;
    do_scan(2'b01, -1, dc, dat, ok, den, db);
    total++; if (dat !== 8'h51) begin bad++; $display("FAIL sec1_data got=%h want=51", dat); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL sec1_enable_path got=%b want=1", ok); end
    total++; if (dc !== LAT) begin bad++; $display("FAIL sec1_latency got=%0d want=%0d", dc, LAT); end
    tick();
    seen_busy = 1'b0; seen_done = 1'b0;
    sec_en = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) seen_busy = 1'b1;
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL sec0_busy got=%b want=0", seen_busy); end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL sec0_done got=%b want=0", seen_done); end
    total++; if (data !== 8'h51) begin bad++; $display("FAIL sec0_data_hold got=%h want=51", data); end
  endtask

  task automatic test_ignore_while_busy();
    int dc; logic [7:0] dat; logic ok; logic [1:0] den; logic db;
    d1 = 4'b1101; d2 = 4'b0110;
    do_scan(2'b11, 5, dc, dat, ok, den, db);
    total++; if (dc !== LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", dc, LAT); end
    total++; if (dat !== 8'h79) begin bad++; $display("FAIL ignore_data got=%h want=79", dat); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ignore_path got=%b want=1", ok); end
    tick();
  endtask

  task automatic test_mid_reset();
    int dc; logic [7:0] dat; logic ok; logic [1:0] den; logic db; logic seen_done;
    d1 = 4'b1101; d2 = 4'b0110;
    sec_en = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 7; i++) tick();
    #2 rst = 1'b1;
    #1;
    total++; if (mux_en_n !== 2'b11) begin bad++; $display("FAIL midrst_en_n got=%b want=11", mux_en_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", data); end
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b want=0", seen_done); end
    d1 = 4'b0010; d2 = 4'b1000;
    do_scan(2'b11, -1, dc, dat, ok, den, db);
    total++; if (dat !== ref_scan(2'b11, d1, d2)) begin bad++; $display("FAIL midrst_rescan_data got=%h want=%h", dat, ref_scan(2'b11, d1, d2)); end
    total++; if (dc !== LAT) begin bad++; $display("FAIL midrst_rescan_latency got=%0d want=%0d", dc, LAT); end
    tick();
  endtask

  task automatic test_random();
    int dc; logic [7:0] dat; logic ok; logic [1:0] den; logic db; logic [1:0] en; logic [7:0] exp;
    for (int n = 0; n < 8; n++) begin
      d1 = 4'($urandom_range(0, 15));
      d2 = 4'($urandom_range(0, 15));
      en = 2'($urandom_range(1, 3));
      exp = ref_scan(en, d1, d2);
      do_scan(en, -1, dc, dat, ok, den, db);
      total++; if (dat !== exp) begin bad++; $display("FAIL rand_data[%0d] en=%b got=%h want=%h", n, en, dat, exp); end
      total++; if (dc !== LAT || ok !== 1'b1) begin bad++; $display("FAIL rand_timing[%0d] lat=%0d path=%b want lat=%0d path=1", n, dc, ok, LAT); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int c, first, second; logic [7:0] d_first, d_second;
    d1 = 4'b1101; d2 = 4'b0110;
    first = -1; second = -1; d_first = '0; d_second = '0;
    sec_en = 2'b11; start = 1'b1;
    c = 0;
    while (c < 60 && second < 0) begin
      tick();
      c++;
      if (done === 1'b1) begin
        if (first < 0) begin first = c; d_first = data; end
        else begin second = c; d_second = data; end
      end
    end
    start = 1'b0;
    total++; if (first < 0 || second < 0) begin bad++; $display("FAIL b2b_pulses first=%0d second=%0d want both seen", first, second); end
    total++; if (second - first !== PERIOD) begin bad++; $display("FAIL b2b_period got=%0d want=%0d", second - first, PERIOD); end
    total++; if (d_first !== 8'h79 || d_second !== 8'h79) begin bad++; $display("FAIL b2b_data got=%h,%h want=79,79", d_first, d_second); end
    for (int i = 0; i < 20; i++) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sec_en = 2'b00;
    d1 = 4'b1101; d2 = 4'b0110;
    test_reset();
    test_basic();
    test_sec1_only();
    test_ignore_while_busy();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
